uart_fifo_cfg_tx: RTL

//  Parametrised UART transmitter: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits.

---
 rtl/uart_fifo_cfg_tx_pkg.sv | 37 +++
 rtl/uart_fifo_cfg_tx_fifo.sv | 86 ++++++++
 rtl/uart_fifo_cfg_tx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_cfg_tx_pkg.sv
// Shared definitions for the UART transmit path (and the future receive path).
//   - parity mode constants (none / odd / even)
//   - FSM state encoding for the frame sequencer
//   - bit counter width, wide enough for the longest frame segment
//   - helpers: parity of a data word, power-of-two test for FIFO sizing
package uart_fifo_cfg_tx_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int BIT_CNT_W = $clog2(13);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Parity over a zero-extended word: even = ^data, odd = ~^data.
  function automatic logic parity_of(input logic [8:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == PARITY_ODD) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_fifo_cfg_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO feeding the UART transmitter.
// Read and write pointers carry one extra wrap bit so full and empty are
// told apart without a separate flag; the occupancy count is kept in its
// own register so consumers can compare it without touching the pointers.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears pointers and count)
//   wr_en      push din (ignored while full)
//   rd_en      pop the head word (ignored while empty)
//   din        word to store
//   dout       head word, valid whenever empty=0
//   count      words held, 0..depth
//   full       no room for another word
//   empty      nothing stored
module uart_tx_fifo
  import uart_fifo_cfg_tx_pkg::*;
#(
  parameter int depth = 4,
  parameter int width = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [width-1:0]               din,
  output logic [width-1:0]               dout,
  output logic [$clog2(depth+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);

  if (!is_pow2(depth) || depth < 2) begin : g_bad_depth
    $error("uart_tx_fifo: depth must be a power of 2 and >= 2");
  end

  logic [width-1:0] mem [depth];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Occupancy count; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_cfg_tx.sv
// uart_fifo_cfg_tx: buffered UART transmitter with compile-time frame format.
// Frames are start(0), data_bits data bits LSB first, optional parity, and
// stop_bits stop bits (1). Words queued in the FIFO go out back-to-back: the
// clock that ends the last stop bit already loads the next word and drives
// the next start bit.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (aborts any frame)
//   tx_valid    write request
//   tx_data     word to send, taken when tx_valid && tx_ready
//   tx_ready    FIFO has room (fifo_count < fifo_depth)
//   tx          serial line, idle high
//   tx_done     one-clock pulse at the end of every completed frame
//   tx_idle     sequencer idle and FIFO empty
//   fifo_count  words waiting in the FIFO
module uart_fifo_cfg_tx
  import uart_fifo_cfg_tx_pkg::*;
#(
  parameter int clock_freq  = 100_000_000,
  parameter int baud_rate   = 115200,
  parameter int data_bits   = 8,
  parameter int parity_mode = 0,
  parameter int stop_bits   = 1,
  parameter int fifo_depth  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tx_valid,
  input  logic [data_bits-1:0]              tx_data,
  output logic                              tx_ready,
  output logic                              tx,
  output logic                              tx_done,
  output logic                              tx_idle,
  output logic [$clog2(fifo_depth+1)-1:0]   fifo_count
);

  localparam int baud_limit = clock_freq / baud_rate;
  localparam int BAUD_W     = (baud_limit > 1) ? $clog2(baud_limit) : 1;

  if (baud_limit < 2) begin : g_bad_baud
    $error("uart_fifo_cfg_tx: clock_freq/baud_rate must be >= 2");
  end
  if (data_bits < 5 || data_bits > 9) begin : g_bad_data_bits
    $error("uart_fifo_cfg_tx: data_bits must be 5..9");
  end
  if (parity_mode != PARITY_NONE && parity_mode != PARITY_ODD && parity_mode != PARITY_EVEN) begin : g_bad_parity
    $error("uart_fifo_cfg_tx: parity_mode must be 0, 1 or 2");
  end
  if (stop_bits != 1 && stop_bits != 2) begin : g_bad_stop
    $error("uart_fifo_cfg_tx: stop_bits must be 1 or 2");
  end

  tx_state_t              state;
  tx_state_t              state_next;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [BAUD_W-1:0]      baud_next;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [BIT_CNT_W-1:0]   bit_next;
  logic [data_bits-1:0]   shifter;
  logic [data_bits-1:0]   shift_next;
  logic                   par_bit;
  logic                   par_next;
  logic                   tx_next;
  logic                   done_next;
  logic                   idle_next;
  logic                   bit_end;
  logic                   push;
  logic                   pop;
  logic [data_bits-1:0]   fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Ready depends only on the registered occupancy, never on this cycle's pop.
  assign tx_ready = ~fifo_full;
  assign push     = tx_valid && tx_ready;
  assign bit_end  = (baud_cnt == BAUD_W'(baud_limit - 1));

  uart_tx_fifo #(
    .depth (fifo_depth),
    .width (data_bits)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (push),
    .rd_en (pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame sequencer: next state, counters, shifter and line level.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shifter;
    par_next   = par_bit;
    tx_next    = tx;
    done_next  = 1'b0;
    pop        = 1'b0;

    case (state)
      ST_IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          // Parity comes from the popped word, before any shifting.
          par_next   = parity_of(9'(fifo_dout), parity_mode);
          state_next = ST_START;
          tx_next    = 1'b0;
        end else begin
          state_next = ST_IDLE;
          tx_next    = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          baud_next  = '0;
          state_next = ST_DATA;
          tx_next    = shifter[0];
          shift_next = {1'b0, shifter[data_bits-1:1]};
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_cnt == BIT_CNT_W'(data_bits - 1)) begin
            bit_next = '0;
            if (parity_mode != PARITY_NONE) begin
              state_next = ST_PARITY;
              tx_next    = par_bit;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next   = bit_cnt + BIT_CNT_W'(1);
            tx_next    = shifter[0];
            shift_next = {1'b0, shifter[data_bits-1:1]};
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = ST_STOP;
          tx_next    = 1'b1;
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_cnt == BIT_CNT_W'(stop_bits - 1)) begin
            bit_next  = '0;
            done_next = 1'b1;
            // Chain straight into the next frame when a word is waiting.
            if (!fifo_empty) begin
              pop        = 1'b1;
              shift_next = fifo_dout;
              par_next   = parity_of(9'(fifo_dout), parity_mode);
              state_next = ST_START;
              tx_next    = 1'b0;
            end else begin
              state_next = ST_IDLE;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next = bit_cnt + BIT_CNT_W'(1);
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        baud_next  = '0;
        bit_next   = '0;
        tx_next    = 1'b1;
      end
    endcase

    // When heading to IDLE no pop happens, so only an incoming push can fill the FIFO.
    if (state_next == ST_IDLE) begin
      idle_next = fifo_empty && !push;
    end else begin
      idle_next = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      tx_idle  <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shifter  <= shift_next;
      par_bit  <= par_next;
      tx       <= tx_next;
      tx_done  <= done_next;
      tx_idle  <= idle_next;
    end
  end

endmodule
